key_line_ctrl: RTL and testbench

- Converts PS/2 key-event bytes into a line of displayable glyph cells and owns the line buffer that the VGA character renderer reads.
- Filters break/extended prefixes, maps make codes to 6-bit glyph indices, and handles backspace and enter.
- Stores a per-cell error flag taken from the checker's result bit, so the renderer colours each cell green or red.
- Sits between the PS/2 receiver/checker and the VGA top.

---
 rtl/key_line_ctrl.sv | 177 +++++++++++++++++
 tb/tb_key_line_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/key_line_ctrl.sv
// key_line_ctrl: turns PS/2 key-event bytes into a line of glyph cells with
// per-cell error flags, and serves a registered read port to the renderer.
module key_line_ctrl #(
    parameter int unsigned COLS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_err,
    input  logic [5:0] rd_col,
    output logic [5:0] rd_glyph,
    output logic       rd_err,
    output logic [5:0] cursor,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned IW    = $clog2(COLS);
    localparam logic [5:0]  COLS6 = 6'(COLS);
    localparam logic [5:0]  BLANK = 6'd63;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BREAK = 2'd2;
    localparam logic [1:0] ST_EXT   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [IW-1:0] clr_idx, clr_nxt;
    logic [5:0]    cursor_nxt;
    logic          ovf_nxt;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [5:0]    wr_glyph;
    logic          wr_err;
    logic [6:0]    map_c;

    logic [5:0]    glyph_mem [COLS];
    logic [COLS-1:0] err_mem;

    // Scan code -> {mapped, glyph index}
    function automatic logic [6:0] map_code(input logic [7:0] c);
        logic [6:0] r;
        r = 7'd0;
        case (c)
            8'h15: r = {1'b1, 6'd0};   8'h1D: r = {1'b1, 6'd1};
            8'h24: r = {1'b1, 6'd2};   8'h2D: r = {1'b1, 6'd3};
            8'h2C: r = {1'b1, 6'd4};   8'h35: r = {1'b1, 6'd5};
            8'h3C: r = {1'b1, 6'd6};   8'h43: r = {1'b1, 6'd7};
            8'h44: r = {1'b1, 6'd8};   8'h4D: r = {1'b1, 6'd9};
            8'h1C: r = {1'b1, 6'd10};  8'h1B: r = {1'b1, 6'd11};
            8'h23: r = {1'b1, 6'd12};  8'h2B: r = {1'b1, 6'd13};
            8'h34: r = {1'b1, 6'd14};  8'h33: r = {1'b1, 6'd15};
            8'h3B: r = {1'b1, 6'd16};  8'h42: r = {1'b1, 6'd17};
            8'h4B: r = {1'b1, 6'd18};  8'h1A: r = {1'b1, 6'd19};
            8'h22: r = {1'b1, 6'd20};  8'h21: r = {1'b1, 6'd21};
            8'h2A: r = {1'b1, 6'd22};  8'h32: r = {1'b1, 6'd23};
            8'h31: r = {1'b1, 6'd24};  8'h3A: r = {1'b1, 6'd25};
            8'h45: r = {1'b1, 6'd26};  8'h16: r = {1'b1, 6'd27};
            8'h1E: r = {1'b1, 6'd28};  8'h26: r = {1'b1, 6'd29};
            8'h25: r = {1'b1, 6'd30};  8'h2E: r = {1'b1, 6'd31};
            8'h36: r = {1'b1, 6'd32};  8'h3D: r = {1'b1, 6'd33};
            8'h3E: r = {1'b1, 6'd34};  8'h46: r = {1'b1, 6'd35};
            8'h41: r = {1'b1, 6'd36};  8'h49: r = {1'b1, 6'd37};
            8'h4A: r = {1'b1, 6'd38};  8'h4C: r = {1'b1, 6'd39};
            8'h52: r = {1'b1, 6'd40};  8'h4E: r = {1'b1, 6'd41};
            8'h55: r = {1'b1, 6'd42};  8'h54: r = {1'b1, 6'd43};
            8'h5B: r = {1'b1, 6'd44};  8'h5D: r = {1'b1, 6'd45};
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    assign map_c = map_code(key_code);

    // Next-state, cursor and buffer-write decode
    always_comb begin
        state_nxt  = state;
        clr_nxt    = clr_idx;
        cursor_nxt = cursor;
        ovf_nxt    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = clr_idx;
        wr_glyph   = BLANK;
        wr_err     = 1'b0;
        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = clr_idx;
                clr_nxt = clr_idx + IW'(1);
                if (clr_idx == IW'(COLS - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (key_valid) begin
                    case (key_code)
                        8'hF0: state_nxt = ST_BREAK;
                        8'hE0: state_nxt = ST_EXT;
                        8'h66: begin
                            if (cursor != 6'd0) begin
                                wr_en      = 1'b1;
                                wr_idx     = IW'(cursor - 6'd1);
                                cursor_nxt = cursor - 6'd1;
                            end
                        end
                        8'h5A: begin
                            cursor_nxt = 6'd0;
                            clr_nxt    = '0;
                            state_nxt  = ST_CLEAR;
                        end
                        default: begin
                            if (map_c[6]) begin
                                if (cursor < COLS6) begin
                                    wr_en      = 1'b1;
                                    wr_idx     = IW'(cursor);
                                    wr_glyph   = map_c[5:0];
                                    wr_err     = key_err;
                                    cursor_nxt = cursor + 6'd1;
                                end else begin
                                    ovf_nxt = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_BREAK: begin
                if (key_valid) state_nxt = ST_IDLE;
            end
            default: begin
                if (key_valid) state_nxt = (key_code == 8'hF0) ? ST_BREAK : ST_IDLE;
            end
        endcase
    end

    // State, cursor and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            cursor   <= 6'd0;
            busy     <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_nxt;
            cursor   <= cursor_nxt;
            busy     <= (state_nxt == ST_CLEAR);
            full     <= (cursor_nxt == COLS6);
            overflow <= ovf_nxt;
        end
    end

    // Line buffer write port (contents initialised by the clear sweep)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            glyph_mem[wr_idx] <= wr_glyph;
            err_mem[wr_idx]   <= wr_err;
        end
    end

    // Registered read port, read-before-write, out-of-range reads blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_glyph <= BLANK;
            rd_err   <= 1'b0;
        end else if (rd_col < COLS6) begin
            rd_glyph <= glyph_mem[IW'(rd_col)];
            rd_err   <= err_mem[IW'(rd_col)];
        end else begin
            rd_glyph <= BLANK;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_line_ctrl.sv
// tb_key_line_ctrl: directed self-checking bench for key_line_ctrl.
module tb_key_line_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_err;
    logic [5:0] rd_col;
    logic [5:0] rd_glyph;
    logic       rd_err;
    logic [5:0] cursor;
    logic       full;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    key_line_ctrl #(.COLS(32)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_code(key_code), .key_err(key_err),
        .rd_col(rd_col), .rd_glyph(rd_glyph), .rd_err(rd_err),
        .cursor(cursor), .full(full), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one key byte for a single cycle; returns at the next falling edge
    task automatic send(input logic [7:0] c, input logic e);
        key_valid = 1'b1;
        key_code  = c;
        key_err   = e;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
        key_err   = 1'b0;
    endtask

    task automatic check_cell(input string tag, input logic [5:0] col,
                              input int g, input int e);
        rd_col = col;
        @(negedge clk);
        check({tag, "_glyph"}, int'(rd_glyph), g);
        check({tag, "_err"}, int'(rd_err), e);
    endtask

    // Count falling edges with busy high, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic enter_and_wait();
        int n;
        send(8'h5A, 1'b0);
        count_busy(n);
        check("sweep_done", int'(busy), 0);
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; key_err = 1'b0; rd_col = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 1);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_glyph", int'(rd_glyph), 63);
        check("rst_err", int'(rd_err), 0);

        // 1: post-reset sweep is exactly 32 cycles, line blank afterwards
        rst = 1'b0;
        count_busy(n);
        check("t1_busy_cycles", n, 32);
        check("t1_cursor", int'(cursor), 0);
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            rd_col = 6'(c);
            @(negedge clk);
            if (rd_glyph !== 6'd63 || rd_err !== 1'b0) bad++;
        end
        check("t1_blank_cells_bad", bad, 0);

        // 2: make / break filtering and per-cell error flag
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1B, 1'b1);
        check("t2_cursor", int'(cursor), 2);
        check_cell("t2_c0", 6'd0, 10, 0);
        check_cell("t2_c1", 6'd1, 11, 1);
        check_cell("t2_c2", 6'd2, 63, 0);

        // 3: extended make and extended break are never written
        enter_and_wait();
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        send(8'h24, 1'b0);
        check("t3_cursor", int'(cursor), 1);
        check_cell("t3_c0", 6'd0, 2, 0);
        check_cell("t3_c1", 6'd1, 63, 0);

        // 4: fill, overflow pulse, backspace from full
        enter_and_wait();
        for (int i = 0; i < 32; i++) send(8'h15, (i == 31) ? 1'b1 : 1'b0);
        check("t4_full", int'(full), 1);
        check("t4_cursor_full", int'(cursor), 32);
        check("t4_ovf_before", int'(overflow), 0);
        send(8'h15, 1'b0);
        check("t4_ovf_pulse", int'(overflow), 1);
        check("t4_cursor_hold", int'(cursor), 32);
        @(negedge clk);
        check("t4_ovf_drop", int'(overflow), 0);
        check_cell("t4_c31", 6'd31, 0, 1);
        send(8'h66, 1'b0);
        check("t4_bs_cursor", int'(cursor), 31);
        check("t4_bs_full", int'(full), 0);
        check_cell("t4_bs_c31", 6'd31, 63, 0);
        check_cell("t4_c30", 6'd30, 0, 0);

        // 5: enter sweep length, key during sweep dropped
        enter_and_wait();
        send(8'h1C, 1'b0); send(8'h1B, 1'b0); send(8'h23, 1'b0);
        check("t5_cursor3", int'(cursor), 3);
        send(8'h5A, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            key_valid = (n == 5);
            key_code  = (n == 5) ? 8'h24 : 8'h00;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("t5_busy_cycles", n, 32);
        check("t5_cursor", int'(cursor), 0);
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            rd_col = 6'(c);
            @(negedge clk);
            if (rd_glyph !== 6'd63 || rd_err !== 1'b0) bad++;
        end
        check("t5_blank_cells_bad", bad, 0);

        // 6: backspace at 0, reset mid-sweep, out-of-range read
        send(8'h66, 1'b0);
        check("t6_bs0_cursor", int'(cursor), 0);
        check("t6_bs0_full", int'(full), 0);
        check_cell("t6_bs0_c0", 6'd0, 63, 0);
        send(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(busy), 1);
        check("t6_rst_cursor", int'(cursor), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("t6_restart_cycles", n, 32);
        for (int i = 0; i < 9; i++) send(8'h1D, 1'b1);
        check("t6_cursor9", int'(cursor), 9);
        check_cell("t6_c8", 6'd8, 1, 1);
        check_cell("t6_col40", 6'd40, 63, 0);
        check_cell("t6_col32", 6'd32, 63, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
